// File: rtl/fsk_frame_ctrl.sv
// Frame sequencer for the 2FSK transmit path: preamble, sync word, PN payload
// and guard slots emitted as a baud-timed bit stream with registered outputs.
module fsk_frame_ctrl #(
    parameter int         CLK_PER_BIT   = 16,
    parameter int         PREAMBLE_BITS = 8,
    parameter logic [7:0] SYNC_WORD     = 8'hD3,
    parameter int         PAYLOAD_BITS  = 32,
    parameter int         GUARD_BITS    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pn_bit,
    output logic pn_en,
    output logic bit_out,
    output logic bit_valid,
    output logic busy,
    output logic done
);

    localparam int CNT_W   = $clog2(CLK_PER_BIT);
    localparam int MAX_A   = (PREAMBLE_BITS > PAYLOAD_BITS) ? PREAMBLE_BITS : PAYLOAD_BITS;
    localparam int MAX_B   = (GUARD_BITS > 8) ? GUARD_BITS : 8;
    localparam int IDX_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int IDX_W   = $clog2(IDX_MAX);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PN    = CNT_W'(CLK_PER_BIT - 2);
    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
    localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(7);
    localparam logic [IDX_W-1:0] PAY_LAST  = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] GRD_LAST  = IDX_W'(GUARD_BITS - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, GUARD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             bit_out_nxt, bit_valid_nxt, busy_nxt, done_nxt, pn_en_nxt;
    logic             wrap;
    logic [2:0]       sync_pos;

    assign wrap     = (cnt == CNT_LAST);
    assign sync_pos = idx[2:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = bit_valid;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        if (state == IDLE) begin
            cnt_nxt       = '0;
            idx_nxt       = '0;
            bit_out_nxt   = 1'b1;
            bit_valid_nxt = 1'b0;
            busy_nxt      = 1'b0;
            if (start) begin
                state_nxt     = PREAMBLE;
                bit_valid_nxt = 1'b1;
                busy_nxt      = 1'b1;
            end
        end else begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                idx_nxt = idx + 1'b1;
                unique case (state)
                    PREAMBLE: begin
                        // Slot k+1 carries ~(k+1)[0], which equals k[0].
                        bit_out_nxt = idx[0];
                        if (idx == PRE_LAST) begin
                            state_nxt   = SYNC;
                            idx_nxt     = '0;
                            bit_out_nxt = SYNC_WORD[7];
                        end
                    end
                    SYNC: begin
                        bit_out_nxt = SYNC_WORD[3'd6 - sync_pos];
                        if (idx == SYNC_LAST) begin
                            state_nxt   = PAYLOAD;
                            idx_nxt     = '0;
                            bit_out_nxt = pn_bit;
                        end
                    end
                    PAYLOAD: begin
                        bit_out_nxt = pn_bit;
                        if (idx == PAY_LAST) begin
                            state_nxt     = GUARD;
                            idx_nxt       = '0;
                            bit_out_nxt   = 1'b1;
                            bit_valid_nxt = 1'b0;
                        end
                    end
                    GUARD: begin
                        if (idx == GRD_LAST) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end

        // Strobe the PN source two cycles before each boundary that loads a payload bit.
        pn_en_nxt = (cnt_nxt == CNT_PN) &&
                    (((state_nxt == SYNC) && (idx_nxt == SYNC_LAST)) ||
                     ((state_nxt == PAYLOAD) && (idx_nxt != PAY_LAST)));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            pn_en     <= 1'b0;
            bit_out   <= 1'b1;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            pn_en     <= pn_en_nxt;
            bit_out   <= bit_out_nxt;
            bit_valid <= bit_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_fsk_frame_ctrl.sv
// Scoreboard bench for fsk_frame_ctrl: expected slots are queued per frame,
// a negedge monitor pops and compares each slot, strobe and frame end.
module tb_fsk_frame_ctrl;

    localparam int CPB       = 4;
    localparam int PAY       = 16;
    localparam int NSLOT     = 8 + 8 + PAY + 4;
    localparam int FRAME_CYC = NSLOT * CPB;

    typedef struct packed {
        logic b;
        logic v;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic pn_bit;
    logic pn_en, bit_out, bit_valid, busy, done;

    int checks = 0;
    int failures = 0;

    slot_t exp_q[$];
    logic [7:0] src = 8'hAA;
    logic [7:0] sw_lfsr = 8'hAA;
    logic [7:0] sync_word = 8'hD3;
    logic [7:0] pay8 = 8'h00;

    int frame_cyc = 0;
    int frame_pn = 0;
    int slot = 0;
    logic prev_busy = 1'b0;
    logic exp_pn;
    slot_t s;

    fsk_frame_ctrl #(
        .CLK_PER_BIT  (CPB),
        .PREAMBLE_BITS(8),
        .SYNC_WORD    (8'hD3),
        .PAYLOAD_BITS (PAY),
        .GUARD_BITS   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pn_bit   (pn_bit),
        .pn_en    (pn_en),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pn_step(input logic [7:0] st);
        return {st[0] ^ st[2] ^ st[3] ^ st[5], st[7:1]};
    endfunction

    // PN bit source: advances on the falling edge after each enable strobe.
    always @(negedge clk) begin
        if (rst) src <= 8'hAA;
        else if (pn_en) src <= pn_step(src);
    end
    assign pn_bit = src[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int k = 0; k < 8; k++) exp_q.push_back('{b: (k % 2 == 0), v: 1'b1});
        for (int j = 0; j < 8; j++) exp_q.push_back('{b: sync_word[7-j], v: 1'b1});
        for (int p = 0; p < PAY; p++) begin
            sw_lfsr = pn_step(sw_lfsr);
            exp_q.push_back('{b: sw_lfsr[0], v: 1'b1});
        end
        for (int g = 0; g < 4; g++) exp_q.push_back('{b: 1'b1, v: 1'b0});
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done) return;
            n++;
        end
        check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every cycle the DUT presents against the queued frame.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            frame_cyc = 0;
            frame_pn  = 0;
        end else begin
            if (busy) begin
                if (!prev_busy) begin
                    frame_cyc = 0;
                    frame_pn  = 0;
                end
                slot = frame_cyc / CPB;
                if (frame_cyc % CPB == 0) begin
                    if (exp_q.size() == 0) begin
                        check("slot_unexpected", 32'd1, 32'd0);
                    end else begin
                        s = exp_q.pop_front();
                        check("bit_out", 32'(bit_out), 32'(s.b));
                        check("bit_valid", 32'(bit_valid), 32'(s.v));
                    end
                    if (slot >= 16 && slot < 24) pay8 = {pay8[6:0], bit_out};
                end
                exp_pn = (frame_cyc % CPB == CPB - 2) && slot >= 15 && slot <= 30;
                check("pn_en_busy", 32'(pn_en), 32'(exp_pn));
                check("done_busy", 32'(done), 32'd0);
                if (pn_en) frame_pn++;
                frame_cyc++;
            end else begin
                check("done", 32'(done), 32'(prev_busy));
                if (prev_busy) begin
                    check("frame_len", 32'(frame_cyc), 32'(FRAME_CYC));
                    check("pn_count", 32'(frame_pn), 32'(PAY));
                end
                check("idle_bit_out", 32'(bit_out), 32'd1);
                check("idle_valid", 32'(bit_valid), 32'd0);
                check("idle_pn_en", 32'(pn_en), 32'd0);
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;

        // Reset and idle.
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_out", 32'(bit_out), 32'd1);
        cycles(10);

        // Full frame; done must land 145 cycles after the start cycle.
        push_frame();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        wait_done(FRAME_CYC + 10, n);
        check("done_cycle", 32'(n + 1), 32'(FRAME_CYC + 1));
        check("first_payload8", 32'(pay8), 32'h0000_00AA);
        cycles(5);

        // Start pulses while busy are ignored.
        push_frame();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(19);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(79);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        wait_done(FRAME_CYC, n);
        cycles(20);
        check("queue_empty_after_busy_start", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of the payload.
        push_frame();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(69);
        rst = 1'b1;
        exp_q.delete();
        sw_lfsr = 8'hAA;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_valid", 32'(bit_valid), 32'd0);
        check("abort_bit_out", 32'(bit_out), 32'd1);
        check("abort_pn_en", 32'(pn_en), 32'd0);
        cycles(5);
        push_frame();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        wait_done(FRAME_CYC + 10, n);
        check("post_abort_done_cycle", 32'(n + 1), 32'(FRAME_CYC + 1));
        cycles(5);

        // Back-to-back frames with start held high.
        for (int f = 0; f < 3; f++) push_frame();
        start = 1'b1;
        dones = 0;
        n = 0;
        while (dones < 3 && n < 3 * (FRAME_CYC + 10)) begin
            @(negedge clk);
            if (done) dones++;
            n++;
        end
        start = 1'b0;
        check("b2b_dones", 32'(dones), 32'd3);
        cycles(20);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsk_frame_ctrl.md
Name: fsk_frame_ctrl

Overview:
- Frame sequencer for the 2FSK transmit path.
- On a start request it emits one frame as a baud-timed bit stream: alternating preamble, fixed sync word, PAYLOAD_BITS bits pulled from the PN bit source via single-cycle enable strobes, then guard bits.
- Its output drives the FSK frequency-select input of the modulator. It is the only block that strobes the PN source's enable.

Parameters:
- CLK_PER_BIT, 16, clk cycles per bit slot; must be >= 2.
- PREAMBLE_BITS, 8, preamble length; pattern 1,0,1,0,... with 1 first.
- SYNC_WORD, 8'hD3, sync word; sent MSB first, 8 bits.
- PAYLOAD_BITS, 32, PN bits per frame; must be >= 1.
- GUARD_BITS, 4, trailing idle slots; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- pn_bit  in  1  current bit from the PN source. The source updates this on the clk falling edge following an enable strobe.
- pn_en  out  1  one-cycle enable strobe to the PN source.
- bit_out  out  1  current transmitted bit; also the FSK frequency select (1 = mark).
- bit_valid  out  1  high during preamble, sync and payload slots.
- busy  out  1  high from first preamble slot through last guard slot.
- done  out  1  one-cycle pulse after the last guard slot.

Behaviour:
- Reset: state IDLE, baud counter 0, bit index 0, pn_en=0, bit_out=1, bit_valid=0, busy=0, done=0. Reset overrides all other inputs, including mid-frame; an aborted frame gives no done pulse.
- States: IDLE -> PREAMBLE -> SYNC -> PAYLOAD -> GUARD -> IDLE.
- Baud counter: counts 0..CLK_PER_BIT-1 within each slot and wraps.
  - A slot boundary is the rising edge at which the counter wraps.
  - bit_out, bit_valid and the state change only at slot boundaries, except on the IDLE->PREAMBLE entry.
- IDLE:
  - bit_out=1, bit_valid=0, busy=0.
  - start=1 at a rising edge moves to PREAMBLE on that edge, with counter=0, bit_out=1, bit_valid=1, busy=1 in the next cycle.
  - Latency from start sample to first slot is 1 cycle.
- start outside IDLE is ignored; no queuing.
- PREAMBLE: slot k (0-based) outputs bit_out = ~k[0].
- SYNC: slot j outputs SYNC_WORD[7-j].
- PAYLOAD:
  - For every payload slot p, pn_en is high for exactly the one cycle where counter==CLK_PER_BIT-2 in the slot preceding p (last SYNC slot for p=0; payload slot p-1 otherwise).
  - At the boundary ending that preceding slot, bit_out <= pn_bit.
  - Exactly PAYLOAD_BITS strobes per frame; pn_en=0 in every other cycle and state.
- GUARD: bit_out=1, bit_valid=0, busy=1 for GUARD_BITS slots.
- Frame end: at the boundary ending the last guard slot, go to IDLE with busy=0; done=1 in that first IDLE cycle only.
- Simultaneous done cycle and start=1: start is accepted (IDLE logic). The new frame begins next cycle and done still pulses once.
- Frame length: (PREAMBLE_BITS+8+PAYLOAD_BITS+GUARD_BITS)*CLK_PER_BIT cycles of busy=1.
- Counters sized by $clog2 of their maxima; no overflow wrap inside a frame.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Reset/idle: hold rst 3 cycles, then idle 10 cycles with start=0 -> bit_out=1, bit_valid=0, busy=0, pn_en=0, done=0 throughout.
- Full frame at CLK_PER_BIT=4, PREAMBLE_BITS=8, SYNC_WORD=8'hD3, PAYLOAD_BITS=16, GUARD_BITS=4, start pulse at cycle 0:
  - busy high cycles 1..144; done only at cycle 145.
  - bit_out per slot = 10101010, 11010011, 16 PN bits, 1111.
- PN handshake, same setup, bit source at power-up seed 8'hAA:
  - exactly 16 pn_en pulses, each at counter==2 of the preceding slot.
  - first 8 payload bits 1,0,1,0,1,0,1,0.
- start while busy: pulse start at cycles 20 and 100 of a frame -> no effect; single done; next frame only on a later start in IDLE.
- Reset mid-frame: assert rst at cycle 70 (payload) -> next cycle all outputs at reset values, no done. A subsequent start yields a complete 144-cycle frame.
- Back-to-back: start held high continuously -> frames abut with done and the new frame's first slot overlapping as specified. Preamble restarts with 1 and pn_en count stays 16 per frame.
